// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit 7-segment scan sequencer with dead-time and leading-zero blanking
module fnd_scan_controller #(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [3:0] i_value,
    input  logic [3:0] i_dp,
    input  logic       i_lz_blank,
    output logic [1:0] o_sel,
    output logic [3:0] o_com,
    output logic [7:0] o_seg,
    output logic       o_frame
);
    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_q, frame_d;
    logic          nz_q, nz_d;
    logic [6:0]    glyph;
    logic          nz_now;
    logic          lz_hide;

    assign nz_now  = nz_q | (i_value != 4'd0);
    assign lz_hide = i_lz_blank & (sel_q != 2'd0) & ~nz_now;

    // hex glyph (active-low a..g) for the nibble the position mux returns
    always_comb begin
        case (i_value)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    end

    // next-state: dark when disabled, otherwise alternate dead-time and lit phases per digit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        com_d   = com_q;
        seg_d   = seg_q;
        frame_d = 1'b0;
        nz_d    = nz_q;
        if (!i_en) begin
            state_d = S_OFF;
            cnt_d   = '0;
            sel_d   = 2'd3;
            com_d   = 4'hF;
            seg_d   = 8'hFF;
            nz_d    = 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    sel_d   = 2'd3;
                    frame_d = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        com_d   = ~(4'b0001 << sel_q);
                        seg_d   = {~i_dp[sel_q], lz_hide ? 7'h7F : glyph};
                        nz_d    = nz_now;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        com_d   = 4'hF;
                        seg_d   = 8'hFF;
                        sel_d   = sel_q - 1'b1;
                        frame_d = (sel_q == 2'd0);
                        nz_d    = nz_q & (sel_q != 2'd0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // state and registered outputs, dark immediately on reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            sel_q   <= 2'd3;
            com_q   <= 4'hF;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            com_q   <= com_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            nz_q    <= nz_d;
        end
    end

    assign o_sel   = sel_q;
    assign o_com   = com_q;
    assign o_seg   = seg_q;
    assign o_frame = frame_q;
endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed scan sequencer for the 4-digit FND (7-segment) display. It drives the select of the 4:1 digit-position mux, reads back the selected nibble, and decodes it to active-low segments. It also drives the active-low digit commons with a dead-time between digits to prevent ghosting, and optionally blanks leading zeros. It sits between the display-value registers/mux and the board FND pins.

Parameters:
ON_CYCLES, 100000, clocks each digit is lit (1 ms at 100 MHz); must be >= 1
BLANK_CYCLES, 1000, dead-time clocks with all commons off before each digit; must be >= 1

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_en  input  1  scan enable; 0 = display dark
i_value  input  4  nibble returned by the position mux for the current o_sel (combinational path)
i_dp  input  4  decimal point request per digit, bit n = digit n, active-high
i_lz_blank  input  1  1 = blank leading zeros on digits 3..1
o_sel  output  2  position select to the mux (3 = i_four ... 0 = i_one)
o_com  output  4  digit commons, active-low, bit n = digit n
o_seg  output  8  {dp,g,f,e,d,c,b,a}, active-low
o_frame  output  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset (async, immediate): state OFF, o_sel=3, o_com=4'b1111, o_seg=8'hFF, o_frame=0, counter=0, nonzero_seen=0. All outputs are registered.
- Scan order is descending: sel 3,2,1,0, then wrap to 3. Digit period = BLANK_CYCLES+ON_CYCLES. Frame = 4x digit period.
- FSM states OFF, BLANK, ON; one counter cnt counts cycles within a state.
- OFF: outputs stay at reset values. If i_en=1, go to BLANK with sel=3 and cnt=0. o_frame=1 in that first BLANK cycle.
- BLANK: o_com=1111 and o_sel is stable so the mux output settles. cnt increments. When cnt==BLANK_CYCLES-1:
  - sample i_value and compute the segments;
  - update nonzero_seen |= (i_value!=0);
  - go to ON with cnt=0.
  - Next cycle: o_com bit sel=0, others 1, and o_seg = the computed value.
- ON: o_com and o_seg hold. When cnt==ON_CYCLES-1:
  - go to BLANK with cnt=0, o_com=1111 and o_seg=8'hFF;
  - sel decrements by 1 (0 wraps to 3);
  - on the wrap: o_frame=1 for that first BLANK cycle and nonzero_seen clears.
- i_en=0 in any state: next cycle is OFF with reset output values, sel=3, cnt=0, nonzero_seen=0. It takes priority over counter expiry.
- Decode (hex, seg[6:0] active-low): 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E.
- Leading-zero blank applies when all of the following hold: i_lz_blank=1, sel!=0, i_value==0, and nonzero_seen==0 (including the digit currently being sampled). Then seg[6:0]=7'h7F. Digit 0 is never blanked.
- seg[7] = ~i_dp[sel], sampled together with i_value. The DP is independent of blanking.
- i_dp and i_lz_blank are sampled only at the end of BLANK. Changes mid-digit take effect from the next digit.
- Counter width is $clog2(max(ON_CYCLES,BLANK_CYCLES)). No overflow is possible.
- Commons are never active in two digits at once. At least BLANK_CYCLES all-off cycles separate every pair of lit digits.

Test Plan:
(all with ON_CYCLES=4, BLANK_CYCLES=2, so one frame = 24 cycles)
1. Reset, then i_en=1; mux returns 1,2,3,4 for sel 3,2,1,0 with lz off. Required sequence:
   - com 0111/seg F9, com 1011/seg A4, com 1101/seg B0, com 1110/seg 99, each lit 4 cycles;
   - 2 cycles of com 1111/seg FF between digits;
   - o_frame pulses every 24 cycles.
2. lz on, digits 0,0,5,0: digits 3 and 2 show seg FF, digit 1 shows 92, digit 0 shows C0. Digits 0,0,0,0: only digit 0 is lit with C0. Digits 0,7,0,0: FF, F8, C0, C0.
3. Value 8 on all digits, i_dp=4'b0100: digit 2 seg 00, others 80. lz on, digits 0,0,0,3, i_dp=4'b1000: digit 3 seg 7F (blank with DP).
4. Drop i_en at ON cycle 2 of digit 1: next cycle com 1111, seg FF, sel 3. Raise i_en: first BLANK cycle with sel=3 and o_frame=1; digit 3 lit 2 cycles later.
5. Assert i_reset asynchronously mid-ON (between clock edges): outputs go to reset values before the next edge. Release with i_en=1: the scan restarts at sel 3.
6. Over 3 full frames, check every cycle that at most one o_com bit is 0 and that o_sel is stable while any common is active.
